// File: rtl/instr_fetch.sv
// instr_fetch -- fetch stage of the core.
//   Owns the PC and issues one instruction-memory read at a time. The returned word
//   is held in a single output slot that feeds the decoder. Execute redirects the
//   stream (taken branch / jal / jalr). Decode back-pressures the stage with stall_i.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_o / imem_addr_o      read request valid / word-aligned address
//   imem_gnt_i                    request accepted this cycle
//   imem_rvalid_i / imem_rdata_i  read response (one per grant, >=1 cycle after it)
//   redirect_i / redirect_pc_i    flush and restart fetch at redirect_pc_i
//   stall_i                       decode cannot take the slot this cycle
//   if_valid_o, if_instr_o, if_pc_o, if_op_o, if_funct3_o, if_instr30_o
//                                 output slot and its pre-split decode fields
module instr_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            stall_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [6:0]      if_op_o,
  output logic [2:0]      if_funct3_o,
  output logic            if_instr30_o
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, DRAIN} state_e;

  typedef struct packed {
    logic            vld;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } slot_t;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] issue_pc_q, issue_pc_d;  // address of the outstanding request
  slot_t           slot_q, slot_d;

  logic consume, req, granted, rsp;

  always_comb begin
    consume = slot_q.vld & ~stall_i;
    // Only ask for a new word when the slot will have room for its response.
    req     = (state_q == REQ) & (~slot_q.vld | ~stall_i);
    granted = req & imem_gnt_i;
    // Responses are only meaningful while one is outstanding.
    rsp     = imem_rvalid_i & ((state_q == WAIT) | (state_q == DRAIN));

    state_d    = state_q;
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    slot_d     = slot_q;

    if (consume) slot_d = '0;

    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (granted) begin
          pc_d       = pc_q + XLEN'(4);
          issue_pc_d = pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (rsp) begin
          slot_d  = '{vld: 1'b1, instr: imem_rdata_i, pc: issue_pc_q};
          state_d = REQ;
        end
      end
      DRAIN: if (rsp) state_d = REQ;
      default: state_d = BOOT;
    endcase

    if (redirect_i) begin
      pc_d   = {redirect_pc_i[XLEN-1:2], 2'b00};
      slot_d = '0;
      unique case (state_q)
        REQ:          state_d = granted ? DRAIN : REQ;
        // A response landing this very cycle retires the outstanding request,
        // so there is nothing left to drain (also true when already draining).
        WAIT, DRAIN:  state_d = rsp ? REQ : DRAIN;
        default:      state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      issue_pc_q <= '0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      slot_q     <= slot_d;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;
  assign if_valid_o   = slot_q.vld;
  assign if_instr_o   = slot_q.instr;
  assign if_pc_o      = slot_q.pc;
  assign if_op_o      = slot_q.instr[6:0];
  assign if_funct3_o  = slot_q.instr[14:12];
  assign if_instr30_o = slot_q.instr[30];

`ifndef SYNTHESIS
  // Memory must not return data when no request is outstanding.
  a_rvalid_protocol: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> ((state_q == WAIT) || (state_q == DRAIN)));
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          N_STEPS  = 3000;
  localparam int          DIR_END  = 19;    // directed warm-up steps (incl. reset)
  localparam int          DRAIN_AT = N_STEPS - 60;
  localparam int          QUIET_AT = N_STEPS - 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [6:0]  if_op_o;
  logic [2:0]  if_funct3_o;
  logic        if_instr30_o;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .if_op_o(if_op_o), .if_funct3_o(if_funct3_o), .if_instr30_o(if_instr30_o)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] exp_pc; bit killed; } pend_t;

  exp_t  scb[$];   // instructions that must appear in the slot, in order
  pend_t pend[$];  // requests granted but not yet answered
  int    checks = 0;
  int    errors = 0;

  // Instruction memory contents: address 0 holds addi x1,x0,10.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the output slot against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req_o) chk("addr_aligned", {30'h0, imem_addr_o[1:0]}, 32'h0);
        if (if_valid_o && stall_i) chk("no_req_when_stalled_full", {31'h0, imem_req_o}, 32'h0);
        if (!if_valid_o) begin
          chk("instr_zero_when_invalid", if_instr_o, 32'h0);
        end else if (!redirect_i) begin
          if (scb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: got pc %h expected no valid output", if_pc_o);
          end else begin
            e = scb[0];
            chk("slot_pc", if_pc_o, e.pc);
            chk("slot_instr", if_instr_o, e.instr);
            chk("slot_op", {25'h0, if_op_o}, {25'h0, e.instr[6:0]});
            chk("slot_funct3", {29'h0, if_funct3_o}, {29'h0, e.instr[14:12]});
            chk("slot_instr30", {31'h0, if_instr30_o}, {31'h0, e.instr[30]});
            if (!stall_i) void'(scb.pop_front());
          end
        end
      end
    end
  end

  // Stimulus, memory responder and reference model.
  initial begin
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] tgt;
    pend_t       p;
    int          rst_cnt  = 2;
    int          wait_cnt = 0;
    int          sr       = -1;  // steps since reset release
    bit          rst_now, rv, rd, directed, quiet;
    logic [31:0] tgts [4];
    tgts[0] = 32'h100; tgts[1] = 32'h203; tgts[2] = 32'hFFFFFFFC; tgts[3] = 32'h0;

    for (int n = 0; n < N_STEPS; n++) begin
      @(posedge clk); #1;
      directed = (n < DIR_END);
      quiet    = (n >= QUIET_AT);
      if (!directed && n < DRAIN_AT && rst_cnt == 0 && $urandom_range(0, 299) == 0) rst_cnt = 2;
      rst_now = (rst_cnt > 0);
      sr = rst_now ? -1 : sr + 1;

      // Response: during reset the late response arrives in the second reset cycle.
      if (rst_cnt == 2)      rv = 1'b0;
      else if (rst_cnt == 1) rv = (pend.size() > 0);
      else                   rv = (pend.size() > 0) && (wait_cnt == 0);
      if (!rv && pend.size() > 0 && wait_cnt > 0 && !rst_now) wait_cnt--;

      rd = !rst_now && !directed && n < DRAIN_AT && ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? $urandom() : tgts[$urandom_range(0, 3)];

      rst           = rst_now;
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_word(pend[0].addr) : $urandom();
      redirect_i    = rd;
      redirect_pc_i = tgt;
      if (directed)           stall_i = (sr >= 9 && sr <= 13);
      else if (n < DRAIN_AT)  stall_i = ($urandom_range(0, 9) < 3);
      else                    stall_i = 1'b0;
      #1;
      imem_gnt_i = !rst_now && !quiet && imem_req_o &&
                   (directed || n >= DRAIN_AT || $urandom_range(0, 9) < 7);

      if (sr == 0) begin
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
        chk("rst_instr", if_instr_o, 32'h0);
        chk("rst_pc", if_pc_o, 32'h0);
      end
      if (directed) begin
        if (sr == 1) chk("first_req", {31'h0, imem_req_o}, 32'h1);
        if (sr == 1) chk("first_addr", imem_addr_o, RESET_PC);
        if (sr == 3) begin
          chk("first_valid_lat", {31'h0, if_valid_o}, 32'h1);
          chk("first_pc", if_pc_o, 32'h0);
          chk("first_op", {25'h0, if_op_o}, 32'h13);
          chk("first_funct3", {29'h0, if_funct3_o}, 32'h0);
          chk("first_instr30", {31'h0, if_instr30_o}, 32'h0);
        end
        if (sr >= 9 && sr <= 13) chk("stall_no_req", {31'h0, imem_req_o}, 32'h0);
        if (sr == 14) chk("release_req", {31'h0, imem_req_o}, 32'h1);
        if (sr == 14) chk("release_addr", imem_addr_o, 32'h10);
      end

      // Reference model of the fetch stream.
      if (rst_now) begin
        pend.delete();
        scb.delete();
        model_pc = RESET_PC;
        wait_cnt = 0;
      end else begin
        if (rv) begin
          p = pend.pop_front();
          if (!p.killed && !rd) scb.push_back('{pc: p.exp_pc, instr: mem_word(p.exp_pc)});
        end
        if (imem_req_o && imem_gnt_i) begin
          chk("one_outstanding", 32'(pend.size()), 32'h0);
          chk("req_addr", imem_addr_o, model_pc);
          pend.push_back('{addr: imem_addr_o, exp_pc: model_pc, killed: 1'b0});
          wait_cnt = directed ? 0 : $urandom_range(0, 2);
          model_pc = model_pc + 32'd4;
        end
        if (rd) begin
          foreach (pend[i]) pend[i].killed = 1'b1;
          model_pc = {tgt[31:2], 2'b00};
          scb.delete();
        end
      end
      if (rst_cnt > 0) rst_cnt--;
    end

    @(posedge clk); #1;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("end_scoreboard_empty", 32'(scb.size()), 32'h0);
    chk("end_no_pending", 32'(pend.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
